// File: rtl/fifo_flex.sv
// fifo_flex: parametrised single-clock FIFO built on an inferred RAM.
// Supports a standard registered read (data one cycle after pop) or a
// first-word-fall-through read where data_out always presents the head word.
// Also provides almost-full/almost-empty thresholds, a synchronous flush,
// and sticky overflow/underflow error flags.
module fifo_flex #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 4,
    parameter int FWFT       = 0,
    parameter int AF_THRESH  = (1 << ADDR_WIDTH) - 2,
    parameter int AE_THRESH  = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   fifo_count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int RAM_DEPTH = 1 << ADDR_WIDTH;
    localparam int COUNT_W   = ADDR_WIDTH + 1;

    localparam logic [COUNT_W-1:0] DEPTH_LVL = COUNT_W'(RAM_DEPTH);
    localparam logic [COUNT_W-1:0] AF_LVL    = COUNT_W'(AF_THRESH);
    localparam logic [COUNT_W-1:0] AE_LVL    = COUNT_W'(AE_THRESH);
    localparam bit                 FWFT_MODE = (FWFT != 0);

    logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];
    logic [ADDR_WIDTH-1:0] wr_pointer;
    logic [ADDR_WIDTH-1:0] rd_pointer;
    logic [COUNT_W-1:0]    ram_count;
    logic                  push_ok;
    logic                  pop_ok;
    logic                  prefetch;
    logic                  ram_read;

    // Status flags come only from registered count/valid state, so push and
    // pop never reach an output combinationally. In FWFT mode a word is only
    // readable once it sits in the output register.
    assign full         = (fifo_count == DEPTH_LVL);
    assign empty        = FWFT_MODE ? !data_valid : (fifo_count == '0);
    assign almost_full  = (fifo_count >= AF_LVL);
    assign almost_empty = (fifo_count <= AE_LVL);

    // Accept/reject decisions use the pre-edge flags and are made
    // independently, so a full FIFO can still pop and an empty one can push.
    // In FWFT mode the output register counts toward fifo_count, so the RAM
    // holds count minus the head word; a prefetch refills the head whenever
    // it is vacant or being consumed this edge.
    always_comb begin
        push_ok   = push && !full;
        pop_ok    = pop && !empty;
        ram_count = fifo_count - COUNT_W'(data_valid);
        prefetch  = FWFT_MODE && (!data_valid || pop_ok) && (ram_count != '0);
        ram_read  = FWFT_MODE ? prefetch : pop_ok;
    end

    // RAM write port; storage is never reset so it maps onto block/dist RAM.
    always_ff @(posedge clk) begin
        if (push_ok && !clear) begin
            mem[wr_pointer] <= data_in;
        end
    end

    // Write pointer advances on every accepted push and wraps naturally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_pointer <= '0;
        end else if (clear) begin
            wr_pointer <= '0;
        end else if (push_ok) begin
            wr_pointer <= wr_pointer + 1'b1;
        end
    end

    // Read pointer advances whenever a word leaves the RAM.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_pointer <= '0;
        end else if (clear) begin
            rd_pointer <= '0;
        end else if (ram_read) begin
            rd_pointer <= rd_pointer + 1'b1;
        end
    end

    // Occupancy count: simultaneous accepted push and pop cancel out.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fifo_count <= '0;
        end else if (clear) begin
            fifo_count <= '0;
        end else if (push_ok && !pop_ok) begin
            fifo_count <= fifo_count + 1'b1;
        end else if (pop_ok && !push_ok) begin
            fifo_count <= fifo_count - 1'b1;
        end
    end

    // Output data register: loaded from the RAM read port, otherwise holds.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_out <= '0;
        end else if (clear) begin
            data_out <= '0;
        end else if (ram_read) begin
            data_out <= mem[rd_pointer];
        end
    end

    // data_valid: a one-cycle strobe after each accepted pop in standard
    // mode; in FWFT mode it marks the output register as holding the head.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_valid <= 1'b0;
        end else if (clear) begin
            data_valid <= 1'b0;
        end else if (!FWFT_MODE) begin
            data_valid <= pop_ok;
        end else if (prefetch) begin
            data_valid <= 1'b1;
        end else if (pop_ok) begin
            data_valid <= 1'b0;
        end
    end

    // Sticky error flags; only reset or clear brings them back down.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clear) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= overflow  | (push && full);
            underflow <= underflow | (pop && empty);
        end
    end

endmodule
